// File: rtl/decode_stage.sv
`timescale 1ns/1ps
// decode_stage: registered 16-bit instruction decoder feeding a 2-entry skid buffer.
// Define DECODE_ILLEGAL_TRAP_EN to add the illegal / err_sticky trap outputs.
module decode_stage #(
    parameter int DATA_W        = 16,
    parameter int SKID_EN_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        alucode,
    output logic [3:0]        rdest,
    output logic [3:0]        rsrc,
    output logic [DATA_W-1:0] imm,
    output logic              use_imm,
    output logic              reg_we,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              is_branch,
    output logic              is_jump,
    output logic [3:0]        cond
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic              illegal,
    output logic              err_sticky
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_CMP    = 4'b0010;
    localparam logic [3:0] ALU_AND    = 4'b0011;
    localparam logic [3:0] ALU_OR     = 4'b0100;
    localparam logic [3:0] ALU_XOR    = 4'b0101;
    localparam logic [3:0] ALU_LSH    = 4'b0110;
    localparam logic [3:0] ALU_LUI    = 4'b0111;
    localparam logic [3:0] ALU_JUMP   = 4'b1000;
    localparam logic [3:0] ALU_BRANCH = 4'b1001;
    localparam logic [3:0] ALU_NONE   = 4'b1111;

    localparam logic [3:0] OP_RTYPE  = 4'h0;
    localparam logic [3:0] OP_MEMJ   = 4'h4;
    localparam logic [3:0] OP_LSHI   = 4'h8;
    localparam logic [3:0] OP_BRANCH = 4'hC;
    localparam logic [3:0] OP_LUI    = 4'hF;
    localparam logic [3:0] KEY_LSH   = 4'h4;
    localparam logic [3:0] EXT_LOAD  = 4'h0;
    localparam logic [3:0] EXT_STORE = 4'h4;
    localparam logic [3:0] EXT_JUMP  = 4'hC;

    typedef struct packed {
        logic [3:0]        alucode;
        logic [3:0]        rdest;
        logic [3:0]        rsrc;
        logic [3:0]        cond;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        logic              reg_we;
        logic              mem_rd;
        logic              mem_wr;
        logic              is_branch;
        logic              is_jump;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic              illegal;
`endif
    } bundle_t;

    localparam bundle_t BUNDLE_RST = '{alucode: ALU_NONE, default: '0};

    if (DATA_W < 16) begin : g_width_chk
        $error("decode_stage: DATA_W must be at least 16");
    end
    if (SKID_EN_DEPTH != 2) begin : g_depth_chk
        $error("decode_stage: only SKID_EN_DEPTH = 2 is supported");
    end

    logic [3:0] w_op;
    logic [3:0] w_ext;
    logic [7:0] w_imm8;
    logic [3:0] w_alu_key;
    logic [3:0] w_alu;
    logic       w_alu_cls;
    logic       w_alu_ok;
    logic       w_imm_form;
    bundle_t    w_dec;

    assign w_op   = instr[15:12];
    assign w_ext  = instr[7:4];
    assign w_imm8 = instr[7:0];

    // R-type selects the ALU function by ext; I-type reuses the same keys via the opcode.
    always_comb begin
        w_alu_cls  = 1'b1;
        w_imm_form = 1'b1;
        w_alu_key  = w_op;
        case (w_op)
            OP_RTYPE: begin
                w_alu_key  = w_ext;
                w_imm_form = 1'b0;
            end
            4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB: begin
            end
            OP_LSHI: w_alu_key = KEY_LSH;
            default: w_alu_cls = 1'b0;
        endcase

        w_alu_ok = 1'b1;
        w_alu    = ALU_NONE;
        case (w_alu_key)
            4'h5:    w_alu = ALU_ADD;
            4'h9:    w_alu = ALU_SUB;
            4'hB:    w_alu = ALU_CMP;
            4'h1:    w_alu = ALU_AND;
            4'h2:    w_alu = ALU_OR;
            4'h3:    w_alu = ALU_XOR;
            KEY_LSH: w_alu = ALU_LSH;
            default: w_alu_ok = 1'b0;
        endcase
    end

    // NOTE: every combinational output starts from a full default, so no path can infer a latch.
    always_comb begin
        w_dec       = BUNDLE_RST;
        w_dec.rdest = instr[11:8];
        w_dec.rsrc  = instr[3:0];
        w_dec.cond  = instr[11:8];
        if (w_alu_cls && w_alu_ok) begin
            w_dec.alucode = w_alu;
            w_dec.reg_we  = (w_alu != ALU_CMP);
            w_dec.use_imm = w_imm_form;
            if (w_imm_form) begin
                if (w_alu == ALU_AND || w_alu == ALU_OR || w_alu == ALU_XOR)
                    w_dec.imm = DATA_W'(w_imm8);
                else
                    w_dec.imm = DATA_W'($signed(w_imm8));
            end
        end else begin
            case (w_op)
                OP_LUI: begin
                    w_dec.alucode = ALU_LUI;
                    w_dec.reg_we  = 1'b1;
                    w_dec.use_imm = 1'b1;
                    w_dec.imm     = DATA_W'({w_imm8, 8'h00});
                end
                OP_BRANCH: begin
                    w_dec.alucode   = ALU_BRANCH;
                    w_dec.is_branch = 1'b1;
                    w_dec.imm       = DATA_W'($signed(w_imm8));
                end
                OP_MEMJ: begin
                    case (w_ext)
                        EXT_JUMP: begin
                            w_dec.alucode = ALU_JUMP;
                            w_dec.is_jump = 1'b1;
                        end
                        EXT_LOAD: begin
                            w_dec.mem_rd = 1'b1;
                            w_dec.reg_we = 1'b1;
                        end
                        EXT_STORE: w_dec.mem_wr = 1'b1;
                        default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                            w_dec.illegal = 1'b1;
`endif
                        end
                    endcase
                end
                default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                    w_dec.illegal = 1'b1;
`endif
                end
            endcase
        end
    end

    logic [1:0] r_state;
    logic       r_in_ready;
    bundle_t    r_main;
    bundle_t    r_skid;
    logic [1:0] w_state_nxt;
    logic       w_accept;
    logic       w_pop;
    logic       w_load_main;
    logic       w_load_skid;
    logic       w_main_from_skid;

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = out_valid & out_ready;

    // in_ready is low in TWO, so an accept can only land in EMPTY or ONE.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: if (w_accept) begin
                w_state_nxt = ST_ONE;
                w_load_main = 1'b1;
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: if (w_pop) begin
                w_state_nxt      = ST_ONE;
                w_load_main      = 1'b1;
                w_main_from_skid = 1'b1;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_load_main = 1'b0;
            w_load_skid = 1'b0;
        end
    end

    // NOTE: both data registers are reset because the main register drives the outputs
    // directly and must show the idle bundle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_main     <= BUNDLE_RST;
            r_skid     <= BUNDLE_RST;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
            if (w_load_main) r_main <= w_main_from_skid ? r_skid : w_dec;
            if (w_load_skid) r_skid <= w_dec;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign alucode   = r_main.alucode;
    assign rdest     = r_main.rdest;
    assign rsrc      = r_main.rsrc;
    assign cond      = r_main.cond;
    assign imm       = r_main.imm;
    assign use_imm   = r_main.use_imm;
    assign reg_we    = r_main.reg_we;
    assign mem_rd    = r_main.mem_rd;
    assign mem_wr    = r_main.mem_wr;
    assign is_branch = r_main.is_branch;
    assign is_jump   = r_main.is_jump;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic r_err_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err_sticky <= 1'b0;
        else if (w_pop && r_main.illegal)
            r_err_sticky <= 1'b1;
    end

    assign illegal    = r_main.illegal;
    assign err_sticky = r_err_sticky;
`endif

endmodule

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
// tb_decode_stage: randomized and directed checks of decode_stage against a queue-based model.
// Honours DECODE_ILLEGAL_TRAP_EN when the design is built with it.
module tb_decode_stage;

    localparam int DATA_W = 16;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [15:0]       instr     = 16'h0;
    logic              flush     = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [3:0]        alucode;
    logic [3:0]        rdest;
    logic [3:0]        rsrc;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic              reg_we;
    logic              mem_rd;
    logic              mem_wr;
    logic              is_branch;
    logic              is_jump;
    logic [3:0]        cond;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic              illegal;
    logic              err_sticky;
    bit                m_sticky;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] m_q[$];

    typedef struct packed {
        logic [3:0]  alucode;
        logic [3:0]  rdest;
        logic [3:0]  rsrc;
        logic [3:0]  cond;
        logic [15:0] imm;
        logic        use_imm;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
    } bundle_t;

    decode_stage #(.DATA_W(DATA_W), .SKID_EN_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alucode   (alucode),
        .rdest     (rdest),
        .rsrc      (rsrc),
        .imm       (imm),
        .use_imm   (use_imm),
        .reg_we    (reg_we),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .cond      (cond)
`ifdef DECODE_ILLEGAL_TRAP_EN
        ,
        .illegal   (illegal),
        .err_sticky(err_sticky)
`endif
    );

    always #5 clk = ~clk;

    function automatic string alu_name(input logic [3:0] k);
        case (k)
            4'h5:    return "add";
            4'h9:    return "sub";
            4'hB:    return "cmp";
            4'h1:    return "and";
            4'h2:    return "or";
            4'h3:    return "xor";
            4'h4:    return "lsh";
            default: return "";
        endcase
    endfunction

    // Operation name of an instruction; empty string means undecodable.
    function automatic string fn_name(input logic [15:0] x);
        case (x[15:12])
            4'h0:                               return alu_name(x[7:4]);
            4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB: return alu_name(x[15:12]);
            4'h8:                               return "lsh";
            4'hF:                               return "lui";
            4'hC:                               return "branch";
            4'h4: begin
                if (x[7:4] == 4'hC) return "jump";
                if (x[7:4] == 4'h0) return "load";
                if (x[7:4] == 4'h4) return "store";
                return "";
            end
            default: return "";
        endcase
    endfunction

    function automatic bundle_t model(input logic [15:0] x);
        bundle_t     b;
        string       f;
        logic [15:0] sx;
        logic [15:0] zx;
        bit          is_alu;
        f      = fn_name(x);
        sx     = {{8{x[7]}}, x[7:0]};
        zx     = {8'h00, x[7:0]};
        is_alu = (f == "add" || f == "sub" || f == "cmp" || f == "and" ||
                  f == "or" || f == "xor" || f == "lsh");
        b         = '0;
        b.alucode = 4'hF;
        b.rdest   = x[11:8];
        b.rsrc    = x[3:0];
        b.cond    = x[11:8];
        if (f == "add")         b.alucode = 4'd0;
        else if (f == "sub")    b.alucode = 4'd1;
        else if (f == "cmp")    b.alucode = 4'd2;
        else if (f == "and")    b.alucode = 4'd3;
        else if (f == "or")     b.alucode = 4'd4;
        else if (f == "xor")    b.alucode = 4'd5;
        else if (f == "lsh")    b.alucode = 4'd6;
        else if (f == "lui")    b.alucode = 4'd7;
        else if (f == "jump")   b.alucode = 4'd8;
        else if (f == "branch") b.alucode = 4'd9;
        if (is_alu) begin
            b.reg_we = (f != "cmp");
            if (x[15:12] != 4'h0) begin
                b.use_imm = 1'b1;
                b.imm     = (f == "and" || f == "or" || f == "xor") ? zx : sx;
            end
        end
        if (f == "lui") begin
            b.reg_we  = 1'b1;
            b.use_imm = 1'b1;
            b.imm     = {x[7:0], 8'h00};
        end
        if (f == "branch") begin
            b.is_branch = 1'b1;
            b.imm       = sx;
        end
        if (f == "jump") b.is_jump = 1'b1;
        if (f == "load") begin
            b.mem_rd = 1'b1;
            b.reg_we = 1'b1;
        end
        if (f == "store") b.mem_wr = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (f == "") b.illegal = 1'b1;
`endif
        return b;
    endfunction

    function automatic bundle_t dut_bundle();
        bundle_t b;
        b.alucode   = alucode;
        b.rdest     = rdest;
        b.rsrc      = rsrc;
        b.cond      = cond;
        b.imm       = imm;
        b.use_imm   = use_imm;
        b.reg_we    = reg_we;
        b.mem_rd    = mem_rd;
        b.mem_wr    = mem_wr;
        b.is_branch = is_branch;
        b.is_jump   = is_jump;
`ifdef DECODE_ILLEGAL_TRAP_EN
        b.illegal   = illegal;
`else
        b.illegal   = 1'b0;
`endif
        return b;
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] x;
        x = 16'($urandom);
        if ($urandom_range(0, 2) != 0) begin
            case ($urandom_range(0, 3))
                0:       x[15:12] = 4'h0;
                1:       x[15:12] = 4'h4;
                default: ;
            endcase
            case ($urandom_range(0, 8))
                0: x[7:4] = 4'h0;
                1: x[7:4] = 4'h1;
                2: x[7:4] = 4'h2;
                3: x[7:4] = 4'h3;
                4: x[7:4] = 4'h4;
                5: x[7:4] = 4'h5;
                6: x[7:4] = 4'h9;
                7: x[7:4] = 4'hB;
                default: x[7:4] = 4'hC;
            endcase
        end
        return x;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = 16'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        m_q.delete();
`ifdef DECODE_ILLEGAL_TRAP_EN
        m_sticky = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock of stimulus; the model advances with the same handshake rules.
    task automatic drive_cycle(input logic v, input logic [15:0] ins, input logic fl,
                               input logic rdy);
        bit acc;
        bit pop;
        in_valid  = v;
        instr     = ins;
        flush     = fl;
        out_ready = rdy;
        acc = v && (m_q.size() < 2);
        pop = rdy && (m_q.size() > 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (pop && fn_name(m_q[0]) == "") m_sticky = 1'b1;
`endif
        @(posedge clk);
        if (fl) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(ins);
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({in_ready, out_valid, alucode, rdest, rsrc, cond, imm,
             use_imm, reg_we, mem_rd, mem_wr, is_branch, is_jump} !==
            {1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0, 6'b0})
            $display("FAIL reset_values: got rdy=%b vld=%b alu=%h imm=%h strobes=%b required rdy=1 vld=0 alu=f imm=0000 strobes=000000",
                     in_ready, out_valid, alucode, imm,
                     {use_imm, reg_we, mem_rd, mem_wr, is_branch, is_jump});
        else pass_cnt++;
`ifdef DECODE_ILLEGAL_TRAP_EN
        total_cnt++;
        if ({illegal, err_sticky} !== 2'b00)
            $display("FAIL reset_trap: got illegal=%b sticky=%b required 0 0", illegal, err_sticky);
        else pass_cnt++;
`endif
    endtask

    task automatic test_basic();
        do_reset();
        drive_cycle(1'b1, 16'h0351, 1'b0, 1'b1);
        total_cnt++;
        if ({out_valid, alucode, rdest, rsrc, reg_we, use_imm} !==
            {1'b1, 4'h0, 4'h3, 4'h1, 1'b1, 1'b0})
            $display("FAIL basic_add: got vld=%b alu=%h rd=%h rs=%h we=%b ui=%b required 1 0 3 1 1 0",
                     out_valid, alucode, rdest, rsrc, reg_we, use_imm);
        else pass_cnt++;
    endtask

    task automatic test_immediates();
        do_reset();
        drive_cycle(1'b1, 16'h52FF, 1'b0, 1'b1);
        total_cnt++;
        if ({alucode, imm, use_imm, reg_we} !== {4'h0, 16'hFFFF, 1'b1, 1'b1})
            $display("FAIL imm_addi: got alu=%h imm=%h ui=%b we=%b required 0 ffff 1 1",
                     alucode, imm, use_imm, reg_we);
        else pass_cnt++;
        drive_cycle(1'b1, 16'h12FF, 1'b0, 1'b1);
        total_cnt++;
        if ({out_valid, alucode, imm, use_imm} !== {1'b1, 4'h3, 16'h00FF, 1'b1})
            $display("FAIL imm_andi: got vld=%b alu=%h imm=%h ui=%b required 1 3 00ff 1",
                     out_valid, alucode, imm, use_imm);
        else pass_cnt++;
        drive_cycle(1'b1, 16'hF1AB, 1'b0, 1'b1);
        total_cnt++;
        if ({alucode, rdest, imm, reg_we} !== {4'h7, 4'h1, 16'hAB00, 1'b1})
            $display("FAIL imm_lui: got alu=%h rd=%h imm=%h we=%b required 7 1 ab00 1",
                     alucode, rdest, imm, reg_we);
        else pass_cnt++;
        drive_cycle(1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        do_reset();
        drive_cycle(1'b1, 16'h0351, 1'b0, 1'b0);
        drive_cycle(1'b1, 16'h0B42, 1'b0, 1'b0);
        total_cnt++;
        if ({in_ready, out_valid, alucode, rdest, rsrc} !== {1'b0, 1'b1, 4'h0, 4'h3, 4'h1})
            $display("FAIL bp_full: got rdy=%b vld=%b alu=%h rd=%h rs=%h required 0 1 0 3 1",
                     in_ready, out_valid, alucode, rdest, rsrc);
        else pass_cnt++;
        drive_cycle(1'b1, 16'h5123, 1'b0, 1'b0);
        total_cnt++;
        if ({in_ready, out_valid, alucode, rdest, rsrc} !== {1'b0, 1'b1, 4'h0, 4'h3, 4'h1})
            $display("FAIL bp_hold: got rdy=%b vld=%b alu=%h rd=%h rs=%h required 0 1 0 3 1",
                     in_ready, out_valid, alucode, rdest, rsrc);
        else pass_cnt++;
        drive_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        total_cnt++;
        if ({in_ready, out_valid, rdest, rsrc} !== {1'b1, 1'b1, 4'hB, 4'h2})
            $display("FAIL bp_second: got rdy=%b vld=%b rd=%h rs=%h required 1 1 b 2",
                     in_ready, out_valid, rdest, rsrc);
        else pass_cnt++;
        drive_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        total_cnt++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL bp_drained: got rdy=%b vld=%b required 1 0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        do_reset();
        drive_cycle(1'b1, 16'h0351, 1'b0, 1'b0);
        drive_cycle(1'b1, 16'h0B42, 1'b0, 1'b0);
        drive_cycle(1'b1, 16'h1234, 1'b1, 1'b0);
        total_cnt++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL flush_empty: got rdy=%b vld=%b required 1 0", in_ready, out_valid);
        else pass_cnt++;
        drive_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        drive_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL flush_no_ghost: got vld=%b required 0", out_valid);
        else pass_cnt++;
        drive_cycle(1'b1, 16'h12FF, 1'b0, 1'b1);
        total_cnt++;
        if ({out_valid, alucode, imm} !== {1'b1, 4'h3, 16'h00FF})
            $display("FAIL flush_resume: got vld=%b alu=%h imm=%h required 1 3 00ff",
                     out_valid, alucode, imm);
        else pass_cnt++;
        drive_cycle(1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic test_illegal();
        do_reset();
        drive_cycle(1'b1, 16'h0007, 1'b0, 1'b1);
        total_cnt++;
        if ({out_valid, alucode, reg_we, mem_rd, mem_wr, is_branch, is_jump} !==
            {1'b1, 4'hF, 5'b0})
            $display("FAIL illegal_nop: got vld=%b alu=%h we=%b rd=%b wr=%b required 1 f 0 0 0",
                     out_valid, alucode, reg_we, mem_rd, mem_wr);
        else pass_cnt++;
`ifdef DECODE_ILLEGAL_TRAP_EN
        total_cnt++;
        if ({illegal, err_sticky} !== 2'b10)
            $display("FAIL illegal_flag: got illegal=%b sticky=%b required 1 0", illegal, err_sticky);
        else pass_cnt++;
        drive_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        total_cnt++;
        if (err_sticky !== 1'b1)
            $display("FAIL sticky_set: got %b required 1", err_sticky);
        else pass_cnt++;
        drive_cycle(1'b1, 16'h0351, 1'b0, 1'b1);
        drive_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        total_cnt++;
        if ({err_sticky, illegal} !== 2'b10)
            $display("FAIL sticky_hold: got sticky=%b illegal=%b required 1 0", err_sticky, illegal);
        else pass_cnt++;
`else
        drive_cycle(1'b0, 16'h0, 1'b0, 1'b1);
`endif
    endtask

    task automatic test_control();
        do_reset();
        drive_cycle(1'b1, 16'h43C0, 1'b0, 1'b1);
        total_cnt++;
        if ({is_jump, is_branch, alucode, cond, reg_we} !== {1'b1, 1'b0, 4'h8, 4'h3, 1'b0})
            $display("FAIL ctrl_jump: got j=%b b=%b alu=%h cond=%h we=%b required 1 0 8 3 0",
                     is_jump, is_branch, alucode, cond, reg_we);
        else pass_cnt++;
        drive_cycle(1'b1, 16'hC3FE, 1'b0, 1'b1);
        total_cnt++;
        if ({is_branch, is_jump, alucode, cond, imm} !== {1'b1, 1'b0, 4'h9, 4'h3, 16'hFFFE})
            $display("FAIL ctrl_branch: got b=%b j=%b alu=%h cond=%h imm=%h required 1 0 9 3 fffe",
                     is_branch, is_jump, alucode, cond, imm);
        else pass_cnt++;
        drive_cycle(1'b1, 16'h4200, 1'b0, 1'b1);
        total_cnt++;
        if ({mem_rd, mem_wr, reg_we, rdest} !== {1'b1, 1'b0, 1'b1, 4'h2})
            $display("FAIL ctrl_load: got rd=%b wr=%b we=%b rdest=%h required 1 0 1 2",
                     mem_rd, mem_wr, reg_we, rdest);
        else pass_cnt++;
        drive_cycle(1'b1, 16'h4145, 1'b0, 1'b1);
        total_cnt++;
        if ({mem_rd, mem_wr, reg_we} !== 3'b010)
            $display("FAIL ctrl_store: got rd=%b wr=%b we=%b required 0 1 0", mem_rd, mem_wr, reg_we);
        else pass_cnt++;
        drive_cycle(1'b1, 16'h02B1, 1'b0, 1'b1);
        total_cnt++;
        if ({alucode, reg_we, use_imm} !== {4'h2, 1'b0, 1'b0})
            $display("FAIL ctrl_cmp: got alu=%h we=%b ui=%b required 2 0 0", alucode, reg_we, use_imm);
        else pass_cnt++;
        drive_cycle(1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic test_midreset();
        do_reset();
        drive_cycle(1'b1, 16'h0351, 1'b0, 1'b0);
        drive_cycle(1'b1, 16'h52FF, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        m_q.delete();
`ifdef DECODE_ILLEGAL_TRAP_EN
        m_sticky = 1'b0;
`endif
        total_cnt++;
        if ({in_ready, out_valid, alucode, imm, reg_we} !== {1'b1, 1'b0, 4'hF, 16'h0, 1'b0})
            $display("FAIL midreset: got rdy=%b vld=%b alu=%h imm=%h we=%b required 1 0 f 0000 0",
                     in_ready, out_valid, alucode, imm, reg_we);
        else pass_cnt++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL midreset_empty: got vld=%b required 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic    v;
        logic    fl;
        logic    rdy;
        bundle_t exp_b;
        bundle_t got_b;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            drive_cycle(v, rand_instr(), fl, rdy);
            total_cnt++;
            if ({in_ready, out_valid} !== {m_q.size() < 2, m_q.size() > 0})
                $display("FAIL rand_status[%0d]: got rdy=%b vld=%b required occupancy %0d",
                         i, in_ready, out_valid, m_q.size());
            else pass_cnt++;
            if (m_q.size() > 0) begin
                exp_b = model(m_q[0]);
                got_b = dut_bundle();
                total_cnt++;
                if (got_b !== exp_b)
                    $display("FAIL rand_bundle[%0d] instr=%h: got %h required %h",
                             i, m_q[0], got_b, exp_b);
                else pass_cnt++;
            end
`ifdef DECODE_ILLEGAL_TRAP_EN
            total_cnt++;
            if (err_sticky !== m_sticky)
                $display("FAIL rand_sticky[%0d]: got %b required %b", i, err_sticky, m_sticky);
            else pass_cnt++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_immediates();
        test_backpressure();
        test_flush();
        test_illegal();
        test_control();
        test_midreset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
